// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage.
// Registered read ports with same-cycle write bypass, two write ports (port 1 wins
// on an index collision), an optional hardwired-zero register, and a clear engine
// that walks every register to zero over DEPTH cycles.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_en,
  input  logic [NRD*$clog2(DEPTH)-1:0] rd_index,
  output logic [NRD*WIDTH-1:0]         rd_out,
  input  logic                         wr0_en,
  input  logic [$clog2(DEPTH)-1:0]     wr0_index,
  input  logic [WIDTH-1:0]             wr0_data,
  input  logic                         wr1_en,
  input  logic [$clog2(DEPTH)-1:0]     wr1_index,
  input  logic [WIDTH-1:0]             wr1_data,
  input  logic                         clr_req,
  output logic                         busy,
  output logic                         clr_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [WIDTH-1:0]     regs_q [DEPTH];
  logic [WIDTH-1:0]     regs_d [DEPTH];
  logic [NRD*WIDTH-1:0] rd_out_q, rd_out_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [0:0]           state_q, state_d;

  assign busy     = (state_q == ST_CLEAR);
  // The final clear cycle is the one where the engine is active on the last index.
  assign clr_done = busy && (cnt_q == LAST_IDX);
  assign rd_out   = rd_out_q;

  // Clear-engine sequencing: start only from IDLE, exit after the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (clr_req) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  // Next register contents: clear engine owns the array while busy, else the write ports.
  always_comb begin
    regs_d = regs_q;
    if (busy) begin
      regs_d[cnt_q] = '0;
    end else begin
      if (wr0_en) regs_d[wr0_index] = wr0_data;
      // Port 1 applied last so it overrides port 0 on the same index.
      if (wr1_en) regs_d[wr1_index] = wr1_data;
    end
    if (ZERO_REG != 0) regs_d[0] = '0;
  end

  // Read data with bypass: zero register, then wr1 hit, then wr0 hit, then stored value.
  always_comb begin
    logic [AW-1:0]    ridx;
    logic [WIDTH-1:0] rval;
    rd_out_d = rd_out_q;
    ridx     = '0;
    rval     = '0;
    if (rd_en && !busy) begin
      for (int p = 0; p < NRD; p++) begin
        ridx = rd_index[p*AW +: AW];
        rval = regs_q[ridx];
        if (wr0_en && (wr0_index == ridx)) rval = wr0_data;
        if (wr1_en && (wr1_index == ridx)) rval = wr1_data;
        if ((ZERO_REG != 0) && (ridx == '0)) rval = '0;
        rd_out_d[p*WIDTH +: WIDTH] = rval;
      end
    end
  end

  // State, counter, read data and register array; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_out_q <= rd_out_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp with default parameters (32x32, 2 read ports, zero reg).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [9:0]  rd_index;
  logic [63:0] rd_out;
  logic        wr0_en;
  logic [4:0]  wr0_index;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_index;
  logic [31:0] wr1_data;
  logic        clr_req;
  logic        busy;
  logic        clr_done;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_index(rd_index), .rd_out(rd_out),
    .wr0_en(wr0_en), .wr0_index(wr0_index), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_index(wr1_index), .wr1_data(wr1_data),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; rd_index = '0;
    wr0_en = 1'b0; wr0_index = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_index = '0; wr1_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic set_read(input logic [4:0] a, input logic [4:0] b);
    rd_en = 1'b1;
    rd_index = {b, a};
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b clr_done=%b expected 0/0", busy, clr_done);
    end
    checks++;
    if (rd_out !== 64'h0) begin
      failures++;
      $display("FAIL reset_rd_out got=%h expected 0", rd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_read(5'd5, 5'd31);
    tick();
    checks++;
    if (rd_out !== 64'h0) begin
      failures++;
      $display("FAIL reset_read_5_31 got=%h expected 0", rd_out);
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    wr0_en = 1'b1; wr0_index = 5'd7; wr0_data = 32'hDEADBEEF;
    set_read(5'd7, 5'd8);
    tick();
    checks++;
    if (rd_out !== {32'h0, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL bypass_wr0 got=%h expected %h", rd_out, {32'h0, 32'hDEADBEEF});
    end
    idle_inputs();
    set_read(5'd8, 5'd7);
    tick();
    checks++;
    if (rd_out !== {32'hDEADBEEF, 32'h0}) begin
      failures++;
      $display("FAIL stored_idx7 got=%h expected %h", rd_out, {32'hDEADBEEF, 32'h0});
    end
    // rd_en low: output holds even though indices change.
    rd_en = 1'b0; rd_index = {5'd0, 5'd0};
    tick();
    checks++;
    if (rd_out !== {32'hDEADBEEF, 32'h0}) begin
      failures++;
      $display("FAIL read_hold got=%h expected %h", rd_out, {32'hDEADBEEF, 32'h0});
    end
    idle_inputs();
  endtask

  task automatic test_wr_priority();
    wr0_en = 1'b1; wr0_index = 5'd3; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_index = 5'd3; wr1_data = 32'h22;
    set_read(5'd3, 5'd3);
    tick();
    checks++;
    if (rd_out !== {32'h22, 32'h22}) begin
      failures++;
      $display("FAIL collide_bypass got=%h expected %h", rd_out, {32'h22, 32'h22});
    end
    // Distinct indices on the two ports, port 1 bypass into read port 1.
    wr0_en = 1'b1; wr0_index = 5'd4; wr0_data = 32'h44;
    wr1_en = 1'b1; wr1_index = 5'd5; wr1_data = 32'h55;
    set_read(5'd3, 5'd5);
    tick();
    checks++;
    if (rd_out !== {32'h55, 32'h22}) begin
      failures++;
      $display("FAIL collide_stored_wr1_bypass got=%h expected %h", rd_out, {32'h55, 32'h22});
    end
    idle_inputs();
    set_read(5'd4, 5'd5);
    tick();
    checks++;
    if (rd_out !== {32'h55, 32'h44}) begin
      failures++;
      $display("FAIL dual_write_stored got=%h expected %h", rd_out, {32'h55, 32'h44});
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    wr0_en = 1'b1; wr0_index = 5'd0; wr0_data = 32'hFFFFFFFF;
    wr1_en = 1'b1; wr1_index = 5'd0; wr1_data = 32'hA5A5A5A5;
    set_read(5'd0, 5'd7);
    tick();
    checks++;
    if (rd_out !== {32'hDEADBEEF, 32'h0}) begin
      failures++;
      $display("FAIL zero_bypass got=%h expected %h", rd_out, {32'hDEADBEEF, 32'h0});
    end
    idle_inputs();
    set_read(5'd3, 5'd0);
    tick();
    checks++;
    if (rd_out !== {32'h0, 32'h22}) begin
      failures++;
      $display("FAIL zero_stored got=%h expected %h", rd_out, {32'h0, 32'h22});
    end
    idle_inputs();
  endtask

  task automatic fill_regs();
    for (int i = 1; i < 32; i++) begin
      wr0_en = 1'b1; wr0_index = 5'(i); wr0_data = 32'h1000_0000 + i;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int busy_cycles;
    int done_cnt;
    int done_at;
    fill_regs();
    set_read(5'd9, 5'd31);
    tick();
    checks++;
    if (rd_out !== {32'h1000_001F, 32'h1000_0009}) begin
      failures++;
      $display("FAIL fill_readback got=%h expected %h", rd_out, {32'h1000_001F, 32'h1000_0009});
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_start busy=%b expected 1", busy);
    end
    busy_cycles = 0; done_cnt = 0; done_at = 0;
    for (int k = 0; k < 100 && busy === 1'b1; k++) begin
      busy_cycles++;
      if (clr_done === 1'b1) begin
        done_cnt++;
        done_at = busy_cycles;
      end
      // Writes, reads and a repeated request while busy must all be ignored;
      // clr_req is also raised on the exit cycle itself.
      clr_req = (clr_done === 1'b1) || (busy_cycles == 5);
      wr1_en = 1'b1; wr1_index = 5'd9; wr1_data = 32'h99;
      set_read(5'd0, 5'd0);
      tick();
    end
    idle_inputs();
    checks++;
    if (busy_cycles != 32) begin
      failures++;
      $display("FAIL flush_busy_cycles got=%0d expected 32", busy_cycles);
    end
    checks++;
    if (done_cnt != 1 || done_at != 32) begin
      failures++;
      $display("FAIL flush_done_pulse count=%0d at=%0d expected 1 at 32", done_cnt, done_at);
    end
    checks++;
    if (rd_out !== {32'h1000_001F, 32'h1000_0009}) begin
      failures++;
      $display("FAIL flush_rd_hold got=%h expected %h", rd_out, {32'h1000_001F, 32'h1000_0009});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL exit_clr_req_ignored busy=%b expected 0", busy);
    end
    for (int i = 0; i < 16; i++) begin
      set_read(5'(2*i), 5'(2*i + 1));
      tick();
      checks++;
      if (rd_out !== 64'h0) begin
        failures++;
        $display("FAIL flush_read_%0d_%0d got=%h expected 0", 2*i, 2*i + 1, rd_out);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflush();
    fill_regs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    // Counter is 0 now; ten more edges bring it to 10.
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (busy !== 1'b1 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL midflush_active busy=%b clr_done=%b expected 1/0", busy, clr_done);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL midflush_reset busy=%b clr_done=%b expected 0/0", busy, clr_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b clr_done=%b expected 0/0", busy, clr_done);
    end
    for (int i = 0; i < 16; i++) begin
      set_read(5'(2*i), 5'(2*i + 1));
      tick();
      checks++;
      if (rd_out !== 64'h0) begin
        failures++;
        $display("FAIL midflush_read_%0d_%0d got=%h expected 0", 2*i, 2*i + 1, rd_out);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_wr_priority();
    test_zero_reg();
    test_flush();
    test_reset_midflush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
